alu_mc: RTL and testbench

//   Parametrised multi-cycle successor of the 8-bit combinational ALU. Operand width is set by WIDTH.
//   It has the same add/sub/shift/logic operation classes and the same C/V/N/Z flags.

---
 rtl/alu_mc.sv | 180 ++++++++++++++++++
 tb/tb_alu_mc.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, serial one-bit-per-clock shifts,
// valid/ready on both sides, result and flags registered and held until consumed.
//
// state | meaning
// IDLE  | ready for a new operation; last result and flags still visible
// SHIFT | serial shift in progress, cnt_q positions remaining
// DONE  | result valid, waiting for OUT_READY
module alu_mc #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] Y,
   output logic             C,
   output logic             V,
   output logic             N,
   output logic             Z
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;

   logic [1:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             is_shift;
   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] imm_y;
   logic             imm_c, imm_v;
   logic [WIDTH-1:0] sh_work;
   logic             sh_out;

   // Immediate result for ops that finish in the accept cycle (incl. count-0 shifts)
   always_comb begin
      b_eff    = (OP == OP_SUB) ? ~B : B;
      sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (OP == OP_SUB)};
      is_shift = (OP == OP_SLL) || (OP == OP_SRL) || (OP == OP_SRA);
      amt      = B[SHW-1:0];
      imm_y    = A;
      imm_c    = 1'b0;
      imm_v    = 1'b0;
      case (OP)
         OP_ADD, OP_SUB: begin
            imm_y = sum[WIDTH-1:0];
            imm_c = sum[WIDTH];
            imm_v = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  imm_y = A & B;
         OP_OR:   imm_y = A | B;
         3'b111:  imm_y = A ^ B;
         default: imm_y = A;
      endcase
   end

   // One-position step of the working register, direction from the latched opcode
   always_comb begin
      sh_work = work_q;
      sh_out  = 1'b0;
      case (op_q)
         OP_SLL: begin
            sh_work = {work_q[WIDTH-2:0], 1'b0};
            sh_out  = work_q[WIDTH-1];
         end
         OP_SRA: begin
            sh_work = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            sh_out  = work_q[0];
         end
         default: begin
            sh_work = {1'b0, work_q[WIDTH-1:1]};
            sh_out  = work_q[0];
         end
      endcase
   end

   // Next-state and result register update
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      y_d     = y_q;
      c_d     = c_q;
      v_d     = v_q;
      n_d     = n_q;
      z_d     = z_q;
      case (state_q)
         S_IDLE: begin
            if (IN_VALID) begin
               op_d = OP;
               if (is_shift && (amt != '0)) begin
                  work_d  = A;
                  cnt_d   = amt;
                  c_d     = 1'b0;
                  state_d = S_SHIFT;
               end else begin
                  y_d     = imm_y;
                  c_d     = imm_c;
                  v_d     = imm_v;
                  n_d     = imm_y[WIDTH-1];
                  z_d     = (imm_y == '0);
                  state_d = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            work_d = sh_work;
            c_d    = sh_out;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == SHW'(1)) begin
               y_d     = sh_work;
               v_d     = 1'b0;
               n_d     = sh_work[WIDTH-1];
               z_d     = (sh_work == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (OUT_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset clears everything, Z included
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         work_q  <= '0;
         y_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         y_q     <= y_d;
         c_q     <= c_d;
         v_q     <= v_d;
         n_q     <= n_d;
         z_q     <= z_d;
      end
   end

   assign IN_READY  = (state_q == S_IDLE);
   assign OUT_VALID = (state_q == S_DONE);
   assign Y         = y_q;
   assign C         = c_q;
   assign V         = v_q;
   assign N         = n_q;
   assign Z         = z_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=8): vector table plus backpressure and reset corners.
module tb_alu_mc;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       IN_VALID = 1'b0;
   logic       IN_READY;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic [2:0] OP = '0;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b0;
   logic [7:0] Y;
   logic       C, V, N, Z;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mc #(.WIDTH(8)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .OP(OP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .Y(Y), .C(C), .V(V), .N(N), .Z(Z)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic       c;
      logic       v;
      logic       n;
      logic       z;
      int         lat;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present an operation, accept it, scramble inputs, and count cycles to OUT_VALID
   task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
      int w;
      w = 0;
      while (!IN_READY && w < 40) begin
         @(posedge CLK); #1; w++;
      end
      check("ready_before_issue", int'(IN_READY), 1);
      OP = op; A = a; B = b; IN_VALID = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0; A = ~a; B = ~b; OP = ~op;
      lat = 1;
      while (!OUT_VALID && lat < 40) begin
         @(posedge CLK); #1; lat++;
      end
   endtask

   initial begin
      int lat;
      vecs[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1};
      vecs[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      vecs[2]  = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[3]  = '{3'd4, 8'h95, 8'h0B, 8'hF2, 1'b1, 1'b0, 1'b1, 1'b0, 4};
      vecs[4]  = '{3'd3, 8'h95, 8'h03, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 4};
      vecs[5]  = '{3'd2, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[6]  = '{3'd2, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2};
      vecs[7]  = '{3'd5, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{3'd7, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[9]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      vecs[10] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1};
      vecs[11] = '{3'd3, 8'h80, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8};
      vecs[12] = '{3'd2, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 8};
      vecs[13] = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1};

      // Reset values
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      check("rst_in_ready", int'(IN_READY), 1);
      check("rst_out_valid", int'(OUT_VALID), 0);
      check("rst_y", int'(Y), 0);
      check("rst_flags", int'({C, V, N, Z}), 0);

      // Table-driven vectors, result held in DONE then consumed
      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("v%0d_y", i), int'(Y), int'(vecs[i].y));
         check($sformatf("v%0d_cvnz", i), int'({C, V, N, Z}),
               int'({vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z}));
         check($sformatf("v%0d_in_ready", i), int'(IN_READY), 0);
         OUT_READY = 1'b1;
         @(posedge CLK); #1;
         OUT_READY = 1'b0;
         check($sformatf("v%0d_consumed", i), int'(OUT_VALID), 0);
      end

      // Backpressure: result held, new requests ignored
      issue(3'd6, 8'hF0, 8'h0F, lat);
      check("bp_lat", lat, 1);
      for (int k = 0; k < 5; k++) begin
         OP = 3'd0; A = 8'h01; B = 8'h01; IN_VALID = 1'b1;
         @(posedge CLK); #1;
         check($sformatf("bp%0d_y", k), int'(Y), 8'hFF);
         check($sformatf("bp%0d_cvnz", k), int'({C, V, N, Z}), 4'b0010);
         check($sformatf("bp%0d_out_valid", k), int'(OUT_VALID), 1);
         check($sformatf("bp%0d_in_ready", k), int'(IN_READY), 0);
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      check("bp_idle_out_valid", int'(OUT_VALID), 0);
      check("bp_idle_in_ready", int'(IN_READY), 1);
      check("bp_idle_y_kept", int'(Y), 8'hFF);
      issue(3'd0, 8'h01, 8'h02, lat);
      check("bp_next_lat", lat, 1);
      check("bp_next_y", int'(Y), 8'h03);
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;

      // Reset in the middle of a long shift
      OP = 3'd3; A = 8'h80; B = 8'h07; IN_VALID = 1'b1;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      check("mid_shift_busy", int'(IN_READY), 0);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("mid_rst_in_ready", int'(IN_READY), 1);
      check("mid_rst_out_valid", int'(OUT_VALID), 0);
      check("mid_rst_y", int'(Y), 0);
      check("mid_rst_flags", int'({C, V, N, Z}), 0);
      issue(3'd0, 8'h01, 8'h01, lat);
      check("post_rst_lat", lat, 1);
      check("post_rst_y", int'(Y), 8'h02);
      check("post_rst_cvnz", int'({C, V, N, Z}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
